pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage MIPS pipeline. It compares register and CP0 dependencies against per-stage Tuse/Tnew, tracks multiply/divide unit occupancy with an internal cycle counter, and drives the enable and clear lines of the F/D, D/E, E/M and M/W pipeline registers. It sits beside the pipeline registers and the CP0 block; Req from CP0 takes priority over every stall decision.

---
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the five-stage pipeline.
// Register, MDU and EPC hazards are detected combinationally in D; the
// multiply/divide unit occupancy is tracked by a small counter FSM.
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       Req,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [3:0] D_rs_Tuse,
  input  logic [3:0] D_rt_Tuse,
  input  logic       D_md,
  input  logic       D_eret,
  input  logic [4:0] E_GRF_A3,
  input  logic [4:0] M_GRF_A3,
  input  logic       E_GRF_write,
  input  logic       M_GRF_write,
  input  logic [3:0] E_Tnew,
  input  logic [3:0] M_Tnew,
  input  logic       E_CP0_write,
  input  logic       M_CP0_write,
  input  logic [4:0] E_CP0_rd,
  input  logic [4:0] M_CP0_rd,
  input  logic       E_start,
  input  logic       E_md_div,
  output logic       F_D_EN,
  output logic       D_E_EN,
  output logic       D_E_clr,
  output logic       E_M_EN,
  output logic       M_W_EN,
  output logic       mdu_start,
  output logic       mdu_busy,
  output logic       mdu_done
);

  localparam logic [3:0] MULT_CYC = 4'd5;
  localparam logic [3:0] DIV_CYC  = 4'd10;
  localparam logic [4:0] EPC_IDX  = 5'd14;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mdu_state_t;

  mdu_state_t state;
  logic [3:0] cnt;

  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall_eret;
  logic stall;

  // Hazard detection: a producer still Tnew cycles away from its result
  // blocks a consumer that needs the value sooner (Tuse). $0 never stalls.
  always_comb begin
    stall_rs = (D_rs != 5'd0) &&
               ((E_GRF_write && (E_GRF_A3 == D_rs) && (E_Tnew > D_rs_Tuse)) ||
                (M_GRF_write && (M_GRF_A3 == D_rs) && (M_Tnew > D_rs_Tuse)));
    stall_rt = (D_rt != 5'd0) &&
               ((E_GRF_write && (E_GRF_A3 == D_rt) && (E_Tnew > D_rt_Tuse)) ||
                (M_GRF_write && (M_GRF_A3 == D_rt) && (M_Tnew > D_rt_Tuse)));
    // A start sitting in E will make the unit busy next cycle, so it counts too.
    stall_md   = D_md && (mdu_busy || E_start);
    // eret must read the EPC value that an in-flight mtc0 is about to write.
    stall_eret = D_eret && ((E_CP0_write && (E_CP0_rd == EPC_IDX)) ||
                            (M_CP0_write && (M_CP0_rd == EPC_IDX)));
    stall      = stall_rs | stall_rt | stall_md | stall_eret;
  end

  // Pipeline register controls; an exception request overrides any stall
  // because the registers flush themselves on Req.
  always_comb begin
    F_D_EN  = Req | ~stall;
    D_E_EN  = 1'b1;
    D_E_clr = ~Req & stall;
    E_M_EN  = 1'b1;
    M_W_EN  = 1'b1;
  end

  assign mdu_start = E_start && !Req && !mdu_busy && reset;

  // MDU occupancy FSM: load latency on an accepted start, count down, and
  // pulse done in the cycle after the last busy cycle. Req never aborts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      mdu_busy <= 1'b0;
      mdu_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mdu_done <= 1'b0;
          if (mdu_start) begin
            cnt      <= E_md_div ? DIV_CYC : MULT_CYC;
            mdu_busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (cnt <= 4'd1) begin
            cnt      <= 4'd0;
            mdu_busy <= 1'b0;
            mdu_done <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt      <= cnt - 4'd1;
            mdu_done <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= 4'd0;
          mdu_busy <= 1'b0;
          mdu_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios followed by random stimulus, all
// checked every cycle against a cycle-number based reference model.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       Req;
  logic [4:0] D_rs, D_rt;
  logic [3:0] D_rs_Tuse, D_rt_Tuse;
  logic       D_md, D_eret;
  logic [4:0] E_GRF_A3, M_GRF_A3;
  logic       E_GRF_write, M_GRF_write;
  logic [3:0] E_Tnew, M_Tnew;
  logic       E_CP0_write, M_CP0_write;
  logic [4:0] E_CP0_rd, M_CP0_rd;
  logic       E_start, E_md_div;
  logic       F_D_EN, D_E_EN, D_E_clr, E_M_EN, M_W_EN;
  logic       mdu_start, mdu_busy, mdu_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit check_en = 0;

  // Reference model: the MDU is described by the absolute cycle numbers of
  // its last busy cycle and its done cycle, scheduled when a start is taken.
  int busy_end = -1;
  int done_at  = -1;
  bit m_start;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .Req(Req),
    .D_rs(D_rs), .D_rt(D_rt), .D_rs_Tuse(D_rs_Tuse), .D_rt_Tuse(D_rt_Tuse),
    .D_md(D_md), .D_eret(D_eret),
    .E_GRF_A3(E_GRF_A3), .M_GRF_A3(M_GRF_A3),
    .E_GRF_write(E_GRF_write), .M_GRF_write(M_GRF_write),
    .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
    .E_CP0_write(E_CP0_write), .M_CP0_write(M_CP0_write),
    .E_CP0_rd(E_CP0_rd), .M_CP0_rd(M_CP0_rd),
    .E_start(E_start), .E_md_div(E_md_div),
    .F_D_EN(F_D_EN), .D_E_EN(D_E_EN), .D_E_clr(D_E_clr),
    .E_M_EN(E_M_EN), .M_W_EN(M_W_EN),
    .mdu_start(mdu_start), .mdu_busy(mdu_busy), .mdu_done(mdu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  // Does source register r, needed in tuse cycles, wait on an in-flight producer?
  function automatic bit src_waits(input logic [4:0] r, input logic [3:0] tuse);
    bit w;
    w = 0;
    if (r != 0) begin
      if (E_GRF_write && E_GRF_A3 == r && int'(E_Tnew) > int'(tuse)) w = 1;
      if (M_GRF_write && M_GRF_A3 == r && int'(M_Tnew) > int'(tuse)) w = 1;
    end
    return w;
  endfunction

  task automatic clear_inputs();
    reset = 1; Req = 0;
    D_rs = 0; D_rt = 0; D_rs_Tuse = 15; D_rt_Tuse = 15; D_md = 0; D_eret = 0;
    E_GRF_A3 = 0; M_GRF_A3 = 0; E_GRF_write = 0; M_GRF_write = 0;
    E_Tnew = 0; M_Tnew = 0; E_CP0_write = 0; M_CP0_write = 0;
    E_CP0_rd = 0; M_CP0_rd = 0; E_start = 0; E_md_div = 0;
  endtask

  task automatic random_inputs();
    int t;
    reset = ($urandom_range(0, 59) != 0);
    Req   = ($urandom_range(0, 9) == 0);
    D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
    t = $urandom_range(0, 4); D_rs_Tuse = (t == 4) ? 4'd15 : 4'(t);
    t = $urandom_range(0, 4); D_rt_Tuse = (t == 4) ? 4'd15 : 4'(t);
    D_md   = ($urandom_range(0, 2) == 0);
    D_eret = ($urandom_range(0, 3) == 0);
    E_GRF_A3 = 5'($urandom_range(0, 3)); M_GRF_A3 = 5'($urandom_range(0, 3));
    E_GRF_write = 1'($urandom_range(0, 1)); M_GRF_write = 1'($urandom_range(0, 1));
    E_Tnew = 4'($urandom_range(0, 3)); M_Tnew = 4'($urandom_range(0, 2));
    E_CP0_write = 1'($urandom_range(0, 1)); M_CP0_write = 1'($urandom_range(0, 1));
    E_CP0_rd = $urandom_range(0, 1) ? 5'd14 : 5'($urandom_range(0, 31));
    M_CP0_rd = $urandom_range(0, 1) ? 5'd14 : 5'($urandom_range(0, 31));
    E_start  = ($urandom_range(0, 2) == 0);
    E_md_div = 1'($urandom_range(0, 1));
  endtask

  // One clock cycle: called at posedge+1 with inputs already applied.
  // Checks outputs mid-cycle, then advances the model at the next edge.
  task automatic run_cycle();
    bit m_busy, m_done, stall;
    #2;
    m_busy = (cyc <= busy_end);
    m_done = (cyc == done_at);
    stall = src_waits(D_rs, D_rs_Tuse) || src_waits(D_rt, D_rt_Tuse) ||
            (D_md && (m_busy || E_start)) ||
            (D_eret && ((E_CP0_write && E_CP0_rd == 14) || (M_CP0_write && M_CP0_rd == 14)));
    m_start = E_start && !Req && !m_busy && reset;
    if (check_en) begin
      check_val("F_D_EN",    F_D_EN,    Req ? 1'b1 : !stall);
      check_val("D_E_EN",    D_E_EN,    1'b1);
      check_val("D_E_clr",   D_E_clr,   Req ? 1'b0 : stall);
      check_val("E_M_EN",    E_M_EN,    1'b1);
      check_val("M_W_EN",    M_W_EN,    1'b1);
      check_val("mdu_start", mdu_start, m_start);
      check_val("mdu_busy",  mdu_busy,  m_busy);
      check_val("mdu_done",  mdu_done,  m_done);
    end
    @(posedge clk);
    if (!reset) begin
      busy_end = -1;
      done_at  = -1;
      check_en = 1;
    end else if (m_start) begin
      busy_end = cyc + (E_md_div ? 10 : 5);
      done_at  = busy_end + 1;
    end
    cyc++;
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    @(posedge clk); #1;
    run_cycle(); run_cycle();
    reset = 1;
    run_cycle();

    // Load-use hazard on $1, then the same shape targeting $0.
    E_GRF_write = 1; E_GRF_A3 = 1; E_Tnew = 2; D_rs = 1; D_rs_Tuse = 1;
    run_cycle();
    E_GRF_A3 = 0; D_rs = 0;
    run_cycle();
    clear_inputs(); run_cycle();

    // mult, then mflo waiting in D until the unit frees up.
    E_start = 1; E_md_div = 0; run_cycle();
    E_start = 0; D_md = 1;
    repeat (8) run_cycle();
    clear_inputs(); run_cycle();

    // div with a Req in the middle; the operation still completes on time.
    E_start = 1; E_md_div = 1; run_cycle();
    E_start = 0; repeat (3) run_cycle();
    Req = 1; run_cycle();
    Req = 0; repeat (9) run_cycle();

    // Start coinciding with Req is dropped; Req also overrides a stall.
    Req = 1; E_start = 1; D_eret = 1; M_CP0_write = 1; M_CP0_rd = 14; run_cycle();
    clear_inputs(); run_cycle();

    // eret after mtc0 EPC, then after mtc0 to another CP0 register.
    D_eret = 1; M_CP0_write = 1; M_CP0_rd = 14; run_cycle();
    M_CP0_rd = 12; run_cycle();
    clear_inputs(); run_cycle();

    // Reset in the third cycle of a div: no busy, no done afterwards.
    E_start = 1; E_md_div = 1; run_cycle();
    E_start = 0; run_cycle(); run_cycle();
    reset = 0; run_cycle();
    reset = 1; repeat (12) run_cycle();

    // Back-to-back mults at minimum spacing.
    E_start = 1; E_md_div = 0;
    repeat (14) run_cycle();
    clear_inputs(); run_cycle();

    for (int i = 0; i < 600; i++) begin
      random_inputs();
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
